// File: rtl/morph_pkg.sv
// Shared types and helpers for the KxK binary morphology stage.
// Mode encoding, pad identity, pipeline depth and kernel legality.
package morph_pkg;

  typedef enum logic [1:0] {
    MORPH_ERODE  = 2'b00,
    MORPH_DILATE = 2'b01,
    MORPH_BYPASS = 2'b10
  } morph_mode_e;

  localparam int LAT = 3;

  // Identity of the reduction: 1 for AND, 0 for OR.
  function automatic logic pad_val(input logic [1:0] mode);
    return (mode == MORPH_ERODE);
  endfunction

  function automatic bit ksize_ok(input int k);
    return (k >= 3) && (k <= 7) && ((k % 2) == 1);
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// Cascaded bit line buffers sharing one column address.
// Reads are combinational; a write shifts each column one line down.
module morph_line_buffer #(
  parameter int DEPTH = 640,
  parameter int LINES = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             din_i,
  output logic [LINES-1:0] tap_o
);

  logic [DEPTH-1:0] mem_q [LINES];

  // Line i holds the pixel i+1 rows above the current one.
  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      tap_o[i] = mem_q[i][addr_i];
    end
  end

  // Push the new pixel in and every line one step deeper.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[0][addr_i] <= din_i;
      for (int i = 1; i < LINES; i++) begin
        mem_q[i][addr_i] <= mem_q[i-1][addr_i];
      end
    end
  end

endmodule

// File: rtl/morph_filter_kxk.sv
// KxK binary erosion/dilation/bypass stage with identity padding.
// Three-stage pipeline: window, per-row reduce, cross-row reduce.
module morph_filter_kxk
  import morph_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int KSIZE     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cfg_mode,
  input  logic       in_vsync,
  input  logic       in_href,
  input  logic       in_clken,
  input  logic       in_bit,
  output logic       out_vsync,
  output logic       out_href,
  output logic       out_clken,
  output logic       out_bit,
  output logic [1:0] mode_active,
  output logic       err_ovf
);

  localparam int K  = KSIZE;
  localparam int CW = $clog2(IMG_HDISP);
  localparam int RW = $clog2(IMG_VDISP);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(K - 1);

  if (!ksize_ok(KSIZE)) begin : g_bad_ksize
    $error("morph_filter_kxk: KSIZE must be odd in 3..7");
  end

  logic          vs_q, hr_q;
  logic          vs_rise, hr_fall;
  logic [CW-1:0] col_q, col_d, col_cur;
  logic          full_q, full_d, full_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [1:0]    mode_q, mode_d, mode_cur;
  logic          ovf_q, ovf_d;

  assign vs_rise  = in_vsync & ~vs_q;
  assign hr_fall  = hr_q & ~in_href;
  assign col_cur  = vs_rise ? '0 : col_q;
  assign full_cur = vs_rise ? 1'b0 : full_q;
  assign row_cur  = vs_rise ? '0 : row_q;
  assign mode_cur = vs_rise ? cfg_mode : mode_q;

  // Counters, mode latch and overflow flag next state.
  always_comb begin
    col_d  = col_cur;
    full_d = full_cur;
    row_d  = row_cur;
    mode_d = mode_cur;
    ovf_d  = vs_rise ? 1'b0 : ovf_q;
    if (!vs_rise && hr_fall && row_q != ROW_MAX)
      row_d = row_q + 1'b1;
    if (in_clken) begin
      if (full_cur) ovf_d = 1'b1;
      if (col_cur == COL_MAX) full_d = 1'b1;
      else col_d = col_cur + 1'b1;
    end
    if (!in_href) begin
      col_d  = '0;
      full_d = 1'b0;
    end
  end

  // Frame and line bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      hr_q   <= 1'b0;
      col_q  <= '0;
      full_q <= 1'b0;
      row_q  <= '0;
      mode_q <= MORPH_ERODE;
      ovf_q  <= 1'b0;
    end else begin
      vs_q   <= in_vsync;
      hr_q   <= in_href;
      col_q  <= col_d;
      full_q <= full_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  logic [K-2:0] tap;

  morph_line_buffer #(
    .DEPTH (IMG_HDISP),
    .LINES (K - 1),
    .AW    (CW)
  ) u_lb (
    .clk    (clk),
    .we_i   (in_clken),
    .addr_i (col_cur),
    .din_i  (in_bit),
    .tap_o  (tap)
  );

  // Row i of the window is i rows up; bit j is j columns left.
  logic [K-1:0] ncol, rv, cv;
  logic [K-1:0] win_q [K];
  logic [K-1:0] val_q [K];
  logic [1:0]   m1_q;

  // New window column and tap validity from the counters.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      ncol[i] = (i == 0) ? in_bit : tap[(i > 0) ? i - 1 : 0];
      rv[i]   = int'(row_cur) >= i;
      cv[i]   = int'(col_cur) >= i;
    end
  end

  // Stage 1: window shift and pad mask on each pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        win_q[i] <= '0;
        val_q[i] <= '0;
      end
      m1_q <= MORPH_ERODE;
    end else if (in_clken) begin
      for (int i = 0; i < K; i++) begin
        win_q[i] <= {win_q[i][K-2:0], ncol[i]};
        val_q[i] <= cv & {K{rv[i]}};
      end
      m1_q <= mode_cur;
    end
  end

  logic [K-1:0] pr [K];
  logic [K-1:0] red_q, red_d;
  logic         pad;

  // Per-row reduction with invalid taps replaced by the identity.
  always_comb begin
    pad = pad_val(m1_q);
    for (int i = 0; i < K; i++) begin
      pr[i]    = (win_q[i] & val_q[i]) | (~val_q[i] & {K{pad}});
      red_d[i] = 1'b0;
      unique case (1'b1)
        m1_q[1]:          red_d[i] = win_q[i][0];
        (m1_q == 2'b00):  red_d[i] = &pr[i];
        default:          red_d[i] = |pr[i];
      endcase
    end
  end

  logic [1:0]     m2_q;
  logic           out_q, out_d;
  logic [LAT-1:0] vs_dly_q, hr_dly_q, ck_dly_q;

  // Cross-row reduction, blanked outside active lines.
  always_comb begin
    out_d = 1'b0;
    unique case (1'b1)
      m2_q[1]:         out_d = red_q[0];
      (m2_q == 2'b00): out_d = &red_q;
      default:         out_d = |red_q;
    endcase
    if (!hr_dly_q[LAT-2]) out_d = 1'b0;
  end

  // Stages 2 and 3 plus sync delays advance every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q    <= '0;
      m2_q     <= MORPH_ERODE;
      out_q    <= 1'b0;
      vs_dly_q <= '0;
      hr_dly_q <= '0;
      ck_dly_q <= '0;
    end else begin
      red_q    <= red_d;
      m2_q     <= m1_q;
      out_q    <= out_d;
      vs_dly_q <= {vs_dly_q[LAT-2:0], in_vsync};
      hr_dly_q <= {hr_dly_q[LAT-2:0], in_href};
      ck_dly_q <= {ck_dly_q[LAT-2:0], in_clken};
    end
  end

  assign out_vsync   = vs_dly_q[LAT-1];
  assign out_href    = hr_dly_q[LAT-1];
  assign out_clken   = ck_dly_q[LAT-1];
  assign out_bit     = out_q;
  assign mode_active = mode_q;
  assign err_ovf     = ovf_q;

endmodule

// File: tb/tb_morph_filter_kxk.sv
// Directed bench for morph_filter_kxk at K=5 and K=3.
// Small 16x8 frames compared against a reference reduction.
module tb_morph_filter_kxk;

  localparam int H = 16;
  localparam int V = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] cfg_mode;
  logic       in_vsync, in_href, in_clken, in_bit;

  logic       a_vs, a_hr, a_ck, a_bit, a_ovf;
  logic [1:0] a_mode;
  logic       b_vs, b_hr, b_ck, b_bit, b_ovf;
  logic [1:0] b_mode;

  morph_filter_kxk #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .KSIZE     (5)
  ) u_k5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_mode    (cfg_mode),
    .in_vsync    (in_vsync),
    .in_href     (in_href),
    .in_clken    (in_clken),
    .in_bit      (in_bit),
    .out_vsync   (a_vs),
    .out_href    (a_hr),
    .out_clken   (a_ck),
    .out_bit     (a_bit),
    .mode_active (a_mode),
    .err_ovf     (a_ovf)
  );

  morph_filter_kxk #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .KSIZE     (3)
  ) u_k3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_mode    (cfg_mode),
    .in_vsync    (in_vsync),
    .in_href     (in_href),
    .in_clken    (in_clken),
    .in_bit      (in_bit),
    .out_vsync   (b_vs),
    .out_href    (b_hr),
    .out_clken   (b_ck),
    .out_bit     (b_bit),
    .mode_active (b_mode),
    .err_ovf     (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit   img [V][H];
  int   cap [2][V][H];
  int   orow [2];
  int   ocol [2];
  logic pvs [2];
  logic phr [2];
  logic [2:0] h1, h2;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic vs,
                     input logic hr, input logic ck,
                     input logic b);
    if (vs && !pvs[d]) begin
      orow[d] = 0;
      ocol[d] = 0;
    end else if (!hr && phr[d]) begin
      orow[d]++;
      ocol[d] = 0;
    end
    if (ck) begin
      if (orow[d] < V && ocol[d] < H)
        cap[d][orow[d]][ocol[d]] = int'(b);
      ocol[d]++;
    end
    pvs[d] = vs;
    phr[d] = hr;
  endtask

  task automatic tick();
    logic [2:0] cur;
    cur = {in_vsync, in_href, in_clken};
    @(posedge clk);
    #1;
    if (!rst_n) begin
      h1 = '0;
      h2 = '0;
      return;
    end
    check("lat_k5", {a_vs, a_hr, a_ck}, h2);
    check("lat_k3", {b_vs, b_hr, b_ck}, h2);
    if (!a_hr) check("blank_k5", a_bit, 0);
    if (!b_hr) check("blank_k3", b_bit, 0);
    h2 = h1;
    h1 = cur;
    mon(0, a_vs, a_hr, a_ck, a_bit);
    mon(1, b_vs, b_hr, b_ck, b_bit);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_k5"},
          {a_vs, a_hr, a_ck, a_bit, a_ovf, a_mode}, 0);
    check({tag, "_k3"},
          {b_vs, b_hr, b_ck, b_bit, b_ovf, b_mode}, 0);
  endtask

  function automatic int model(int k, logic [1:0] m,
                               int r, int c);
    int acc, t, rr, cc;
    if (m[1]) return int'(img[r][c]);
    acc = (m == 2'b00) ? 1 : 0;
    for (int dr = 0; dr < k; dr++) begin
      for (int dc = 0; dc < k; dc++) begin
        rr = r - dr;
        cc = c - dc;
        if (rr < 0 || cc < 0) t = (m == 2'b00) ? 1 : 0;
        else t = int'(img[rr][cc]);
        if (m == 2'b00) acc = acc & t;
        else acc = acc | t;
      end
    end
    return acc;
  endfunction

  task automatic fill(input int kind, input int den);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        case (kind)
          0: img[r][c] = 1'b0;
          1: img[r][c] = 1'b1;
          default:
            img[r][c] = ($urandom_range(den - 1, 0) != 0)
                        ^ (kind == 3);
        endcase
  endtask

  task automatic drive_frame(input logic [1:0] mode,
                             input int sw_row,
                             input logic [1:0] sw_mode,
                             input bit gaps,
                             input int rst_row);
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < V; r++)
        for (int c = 0; c < H; c++)
          cap[d][r][c] = 2;
    cfg_mode = mode;
    in_vsync = 1'b1;
    tick();
    check("mode_k5", a_mode, mode);
    check("mode_k3", b_mode, mode);
    tick();
    in_vsync = 1'b0;
    tick();
    tick();
    for (int r = 0; r < V; r++) begin
      if (r == sw_row) cfg_mode = sw_mode;
      if (r == rst_row) begin
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid0");
        tick();
        check_quiet("rst_mid1");
        tick();
        check_quiet("rst_mid2");
        rst_n = 1'b1;
      end
      in_href = 1'b1;
      for (int c = 0; c < H; c++) begin
        if (gaps)
          while ($urandom_range(1, 0) == 0) tick();
        in_clken = 1'b1;
        in_bit   = img[r][c];
        tick();
        in_clken = 1'b0;
        in_bit   = 1'b0;
      end
      in_href = 1'b0;
      repeat (3) tick();
      if (sw_row >= 0 && r >= sw_row)
        check("mode_hold", a_mode, mode);
    end
    repeat (5) tick();
  endtask

  task automatic cmp_frame(input string tag,
                           input logic [1:0] m);
    int k;
    for (int d = 0; d < 2; d++) begin
      k = (d == 0) ? 5 : 3;
      for (int r = 0; r < V; r++)
        for (int c = 0; c < H; c++)
          check($sformatf("%s_k%0d_r%0d_c%0d", tag, k, r, c),
                cap[d][r][c], model(k, m, r, c));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_mode = 2'b00;
    in_vsync = 1'b0;
    in_href  = 1'b0;
    in_clken = 1'b0;
    in_bit   = 1'b0;
    h1 = '0;
    h2 = '0;
    for (int d = 0; d < 2; d++) begin
      orow[d] = 0;
      ocol[d] = 0;
      pvs[d]  = 1'b0;
      phr[d]  = 1'b0;
    end
    repeat (3) tick();
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    fill(1, 2);
    drive_frame(2'b00, -1, 2'b00, 1'b0, -1);
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < V; r++)
        for (int c = 0; c < H; c++)
          check($sformatf("ones_d%0d_r%0d_c%0d", d, r, c),
                cap[d][r][c], 1);
    cmp_frame("erode_ones", 2'b00);

    fill(0, 2);
    img[4][4] = 1'b1;
    drive_frame(2'b01, -1, 2'b00, 1'b0, -1);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        check($sformatf("dot_k3_r%0d_c%0d", r, c),
              cap[1][r][c],
              (r >= 4 && r <= 6 && c >= 4 && c <= 6) ? 1 : 0);
    cmp_frame("dilate_dot", 2'b01);

    fill(3, 16);
    drive_frame(2'b00, 3, 2'b01, 1'b0, -1);
    cmp_frame("mode_switch", 2'b00);

    fill(2, 8);
    drive_frame(2'b01, -1, 2'b00, 1'b1, -1);
    cmp_frame("gaps_dilate", 2'b01);

    fill(2, 2);
    drive_frame(2'b10, -1, 2'b00, 1'b1, -1);
    cmp_frame("gaps_bypass", 2'b10);

    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
    in_href = 1'b1;
    for (int i = 0; i < H + 2; i++) begin
      in_clken = 1'b1;
      in_bit   = 1'b1;
      tick();
      if (i == H - 1) begin
        check("ovf_pre_k5", a_ovf, 0);
        check("ovf_pre_k3", b_ovf, 0);
      end
      if (i == H) begin
        check("ovf_set_k5", a_ovf, 1);
        check("ovf_set_k3", b_ovf, 1);
      end
    end
    in_clken = 1'b0;
    in_bit   = 1'b0;
    in_href  = 1'b0;
    repeat (4) tick();
    check("ovf_hold_k5", a_ovf, 1);
    check("ovf_hold_k3", b_ovf, 1);
    in_vsync = 1'b1;
    tick();
    check("ovf_clr_k5", a_ovf, 0);
    check("ovf_clr_k3", b_ovf, 0);
    in_vsync = 1'b0;
    repeat (4) tick();

    fill(1, 2);
    drive_frame(2'b01, -1, 2'b00, 1'b0, 5);
    fill(0, 2);
    img[6][10] = 1'b1;
    drive_frame(2'b01, -1, 2'b00, 1'b0, -1);
    cmp_frame("post_rst", 2'b01);
    check("post_rst_edge_k3", cap[1][0][0], 0);
    check("post_rst_dot_k3", cap[1][7][12], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morph_filter_kxk.md
# morph_filter_kxk

Parametrised binary morphology stage for the frame-difference motion-detection chain. It sits between binarisation and the bounding-box/marking logic and replaces the fixed 5x5 erosion with a KxK window of configurable size. The operation (erosion, dilation or bypass) is selected per frame. Out-of-image window taps are padded with the operation's identity value, so image borders are not eroded or dilated artificially.

## Interface
Parameters:
- IMG_HDISP, 640, active pixels per line; sets line-buffer depth.
- IMG_VDISP, 480, active lines per frame; used only for the row-counter width.
- KSIZE, 5, kernel edge length; odd, legal range 3..7; elaboration error otherwise.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_mode  in  2  00 erosion, 01 dilation, 10/11 bypass
- in_vsync  in  1  frame sync
- in_href  in  1  line valid
- in_clken  in  1  pixel valid
- in_bit  in  1  binary pixel, 1 = foreground
- out_vsync  out  1  in_vsync delayed 3 clk
- out_href  out  1  in_href delayed 3 clk
- out_clken  out  1  in_clken delayed 3 clk
- out_bit  out  1  filtered pixel; forced 0 while out_href = 0
- mode_active  out  2  mode latched for the current frame
- err_ovf  out  1  sticky flag: a line carried more than IMG_HDISP pixels

## Operation
- **Mode latch:** mode_active loads cfg_mode on the in_vsync rising edge only. Changes mid-frame are ignored until the next frame.
- **Column counter:**
  - Cleared while in_href = 0.
  - Increments on each in_clken and saturates at IMG_HDISP-1.
  - A clken that arrives while the counter is already saturated sets err_ovf and writes to the last line-buffer location.
- **Row counter:**
  - Cleared on the in_vsync rising edge.
  - Increments on each in_href falling edge and saturates at KSIZE-1. Only "row < KSIZE-1" is needed.
- **Line buffers:** KSIZE-1 lines of IMG_HDISP bits, organised as a cascade. On each in_clken:
  - Read all lines at the column address.
  - Write in_bit into line 0 and line i into line i+1.
- **Window:** KxK shift register. On each in_clken it shifts left by one column and loads the new column {line outputs, in_bit}.
- **Output definition:** the output at raster position (r,c) is the reduction over rows r-K+1..r and columns c-K+1..c, i.e. the window's bottom-right tap is the current pixel. The result is therefore offset by (K-1)/2 in both axes; downstream compensates.
- **Padding:** any tap with row index < 0 or column index < 0 is replaced by the pad value. Pad is 1 for erosion and 0 for dilation. This is decided from the row and column counters, not from buffer contents.
- **Reduction:**
  - Erosion: AND of all K² taps.
  - Dilation: OR of all K² taps.
  - Bypass: the current tap (bottom-right) only.
- **Pipeline stages:**
  - Stage 1: window and pad mask.
  - Stage 2: per-row reduction into a KSIZE-bit register.
  - Stage 3: cross-row reduction into the out_bit register.
- **err_ovf:** set as described above; cleared on the in_vsync rising edge.

## Timing
- **Latency:** in_clken high in cycle t produces out_clken high in cycle t+3, with out_bit valid in that cycle. out_vsync and out_href track with the same 3-cycle delay.
- **Pipeline registers:** the three stage registers advance every clk. Window shifts and buffer writes are gated by in_clken, so gaps in clken inside a line are tolerated.
- **Reset values:**
  - All outputs 0, mode_active = 00, err_ovf = 0.
  - Counters cleared.
  - Line-buffer RAM is not cleared; the row-counter padding masks stale data.
- **Reset mid-frame:** the output goes quiet immediately. The first frame after release begins at the next in_vsync rising edge. Data arriving before that edge is processed with row = 0 padding.
- **Simultaneous events:** an in_vsync rising edge together with in_clken clears the counters first. That pixel is treated as row 0, column 0.

## Structure
- **Package morph_pkg:**
  - Mode enum (MORPH_ERODE, MORPH_DILATE, MORPH_BYPASS).
  - Function pad_val(mode).
  - Constant LAT = 3.
  - KSIZE legality check.
- **Sub-module morph_line_buffer:** KSIZE-1 cascaded single-port-per-line bit RAMs with a shared address, a write enable and a tap output vector. It is instantiated once.
- **Top level:** counters, mode latch, window, pad mask, reduction pipeline and sync delays.

## Test plan
- **Erosion, K=5, 16x8 frame, all-ones:** output is all 1, including the first 4 rows and columns (pad = 1).
- **Dilation, K=3, single 1 at (4,4) in a 16x8 zero frame:** out_bit = 1 exactly at rows 4..6, cols 4..6; all else 0.
- **Mode change mid-frame:** cfg_mode switches 00→01 at line 3. mode_active stays 00 until the next in_vsync rise, and the whole frame is eroded.
- **Overflow:** a line with IMG_HDISP+2 clkens sets err_ovf on the 1st extra pixel; the flag stays high until the next vsync rise, then reads 0.
- **Latency and gaps:** a random clken pattern with 50% duty gives out_clken equal to in_clken delayed exactly 3 clk, with bits matching the golden model.
- **Reset mid-frame:** assert rst_n low at line 5 for 2 clk. All outputs are 0 during reset. The next frame matches the golden model despite stale RAM contents.
